// File: rtl/sysbus_rr_arbiter.sv
// sysbus_rr_arbiter: N-channel system-bus arbiter.
// Grants one requester at a time, buffers a full burst, and runs the whole
// read or write transaction on the single memory-side port before releasing.
// Optional feature macro: SYSBUS_ARB_RR_EN
//   defined   -> round-robin grant starting after the last granted channel
//   undefined -> fixed priority, lowest-indexed requesting channel wins

`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b1
`endif

module sysbus_rr_arbiter #(
    parameter int NUM_CH         = 2,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BURST_LEN      = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CH-1:0]                    reqcyc,
    output logic [NUM_CH-1:0]                    reqack,
    input  logic [NUM_CH*BUS_DATA_WIDTH-1:0]     req,
    input  logic [NUM_CH*BUS_TAG_WIDTH-1:0]      reqtag,
    output logic [NUM_CH-1:0]                    respcyc,
    input  logic [NUM_CH-1:0]                    respack,
    output logic [BUS_DATA_WIDTH-1:0]            resp,
    output logic [BUS_TAG_WIDTH-1:0]             resptag,
    output logic                                 bus_reqcyc,
    input  logic                                 bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0]            bus_req,
    output logic [BUS_TAG_WIDTH-1:0]             bus_reqtag,
    input  logic                                 bus_respcyc,
    output logic                                 bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0]            bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]             bus_resptag
);

    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACKREQ,
        WRDATA,
        MEMADDR,
        MEMWR,
        MEMRD,
        MEMRESP,
        RESP
    } state_t;

    state_t                     state;
    logic [GW-1:0]              gnt;
    logic [CW-1:0]              cnt;
    logic [BUS_DATA_WIDTH-1:0]  addr_q;
    logic [BUS_TAG_WIDTH-1:0]   tag_q;
    logic [BUS_DATA_WIDTH-1:0]  buffer [BURST_LEN];

    logic [BUS_DATA_WIDTH-1:0]  req_ch [NUM_CH];
    logic [BUS_TAG_WIDTH-1:0]   tag_ch [NUM_CH];
    logic                       any_req;
    logic [GW-1:0]              gnt_sel;
    logic                       last_beat;

    // The memory-side response tag is not needed: the latched request tag is returned.
    logic unused_bus_resptag;
    assign unused_bus_resptag = ^bus_resptag;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign req_ch[gi] = req[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
            assign tag_ch[gi] = reqtag[gi*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
        end
    endgenerate

    assign any_req   = |reqcyc;
    assign last_beat = (cnt == LAST_BEAT);

`ifdef SYSBUS_ARB_RR_EN
    logic [GW-1:0] rr_ptr;

    // Round-robin pick: first requester at or above the pointer, else wrap to the lowest.
    always_comb begin
        logic found;
        found   = 1'b0;
        gnt_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && reqcyc[i] && (i >= int'(rr_ptr))) begin
                found   = 1'b1;
                gnt_sel = GW'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && reqcyc[i]) begin
                found   = 1'b1;
                gnt_sel = GW'(i);
            end
        end
    end
`else
    // Fixed-priority pick: lowest-indexed requester wins.
    always_comb begin
        logic found;
        found   = 1'b0;
        gnt_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && reqcyc[i]) begin
                found   = 1'b1;
                gnt_sel = GW'(i);
            end
        end
    end
`endif

    // Transaction sequencer: state, grant, beat counter and arbitration pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            gnt   <= '0;
`ifdef SYSBUS_ARB_RR_EN
            rr_ptr <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt   <= gnt_sel;
                        cnt   <= '0;
                        state <= ACKREQ;
`ifdef SYSBUS_ARB_RR_EN
                        rr_ptr <= (gnt_sel == GW'(NUM_CH - 1)) ? '0 : gnt_sel + 1'b1;
`endif
                    end
                end
                ACKREQ: begin
                    state <= (tag_q[BUS_TAG_WIDTH-1] == `SYSBUS_WRITE) ? WRDATA : MEMRD;
                end
                WRDATA: begin
                    if (reqcyc[gnt]) begin
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= MEMADDR;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                MEMADDR: begin
                    if (bus_reqack) state <= MEMWR;
                end
                MEMWR: begin
                    if (bus_reqack) begin
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                MEMRD: begin
                    if (bus_reqack) state <= MEMRESP;
                end
                MEMRESP: begin
                    if (bus_respcyc) begin
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= RESP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (respack[gnt]) begin
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath capture: request address/tag at grant, burst beats into the buffer.
    always_ff @(posedge clk) begin
        if (state == IDLE && any_req) begin
            addr_q <= req_ch[gnt_sel];
            tag_q  <= tag_ch[gnt_sel];
        end
        if (state == WRDATA && reqcyc[gnt]) begin
            buffer[cnt] <= req_ch[gnt];
        end
        if (state == MEMRESP && bus_respcyc) begin
            buffer[cnt] <= bus_resp;
        end
    end

    // Handshake and data outputs decoded from the current state; all zero in IDLE.
    always_comb begin
        reqack      = '0;
        respcyc     = '0;
        resp        = '0;
        resptag     = '0;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        case (state)
            ACKREQ: reqack[gnt] = 1'b1;
            WRDATA: reqack[gnt] = reqcyc[gnt];
            MEMADDR, MEMRD: begin
                bus_reqcyc = 1'b1;
                bus_req    = addr_q;
                bus_reqtag = tag_q;
            end
            MEMWR: begin
                bus_reqcyc = 1'b1;
                bus_req    = buffer[cnt];
                bus_reqtag = tag_q;
            end
            MEMRESP: bus_respack = bus_respcyc;
            RESP: begin
                respcyc[gnt] = 1'b1;
                resp         = buffer[cnt];
                resptag      = tag_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sysbus_rr_arbiter.sv
// Directed testbench for sysbus_rr_arbiter: a 2-channel/8-beat instance and a
// 4-channel/4-beat instance. Expected grant order follows SYSBUS_ARB_RR_EN.

module tb_sysbus_rr_arbiter;

    logic clk;
    logic reset;

    // Instance A: NUM_CH=2, BURST_LEN=8, 64-bit data, 13-bit tag
    logic [1:0]    reqcyc, reqack, respcyc, respack;
    logic [127:0]  req;
    logic [25:0]   reqtag;
    logic [63:0]   resp, bus_req, bus_resp;
    logic [12:0]   resptag, bus_reqtag, bus_resptag;
    logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;

    // Instance B: NUM_CH=4, BURST_LEN=4, 32-bit data, 8-bit tag
    logic [3:0]    b_reqcyc, b_reqack, b_respcyc, b_respack;
    logic [127:0]  b_req;
    logic [31:0]   b_reqtag;
    logic [31:0]   b_resp, b_bus_req, b_bus_resp;
    logic [7:0]    b_resptag, b_bus_reqtag, b_bus_resptag;
    logic          b_bus_reqcyc, b_bus_reqack, b_bus_respcyc, b_bus_respack;

    int checks = 0;
    int errors = 0;

    sysbus_rr_arbiter #(.NUM_CH(2), .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .BURST_LEN(8)) dut_a (
        .clk(clk), .reset(reset),
        .reqcyc(reqcyc), .reqack(reqack), .req(req), .reqtag(reqtag),
        .respcyc(respcyc), .respack(respack), .resp(resp), .resptag(resptag),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respcyc(bus_respcyc), .bus_respack(bus_respack), .bus_resp(bus_resp), .bus_resptag(bus_resptag)
    );

    sysbus_rr_arbiter #(.NUM_CH(4), .BUS_DATA_WIDTH(32), .BUS_TAG_WIDTH(8), .BURST_LEN(4)) dut_b (
        .clk(clk), .reset(reset),
        .reqcyc(b_reqcyc), .reqack(b_reqack), .req(b_req), .reqtag(b_reqtag),
        .respcyc(b_respcyc), .respack(b_respack), .resp(b_resp), .resptag(b_resptag),
        .bus_reqcyc(b_bus_reqcyc), .bus_reqack(b_bus_reqack), .bus_req(b_bus_req), .bus_reqtag(b_bus_reqtag),
        .bus_respcyc(b_bus_respcyc), .bus_respack(b_bus_respack), .bus_resp(b_bus_resp), .bus_resptag(b_bus_resptag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int g, output int w);
        g = -1;
        w = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (reqack != 2'b00) begin
                w = k;
                g = (reqack == 2'b01) ? 0 : (reqack == 2'b10) ? 1 : -2;
                break;
            end
        end
        if (w == 0) check_eq("grant_timeout", 64'd0, 64'd1);
    endtask

    // Full read on instance A acting as requester and memory.
    task automatic read_txn(input logic [1:0] mask, input int exp_ch, input logic [63:0] abase,
                            input logic [63:0] dbase, input int ackdly, input int sbeat,
                            input int slen, input bit hold);
        int g, w, gi;
        logic [63:0] a_exp;
        logic [12:0] t_exp;
        logic [1:0]  onehot;
        for (int c = 0; c < 2; c++) begin
            req[c*64 +: 64]    = abase + 64'(c) * 64'h100;
            reqtag[c*13 +: 13] = 13'h0A0 + 13'(c);
        end
        reqcyc = mask;
        wait_grant(g, w);
        check_eq("grant", 64'(g), 64'(exp_ch));
        check_eq("grant_latency", 64'(w), 64'd1);
        gi     = (g == 1) ? 1 : 0;
        a_exp  = abase + 64'(gi) * 64'h100;
        t_exp  = 13'h0A0 + 13'(gi);
        onehot = 2'b01 << gi;
        if (!hold) reqcyc = 2'b00;
        cyc();
        check_eq("rd_ack_once", 64'(reqack), 64'd0);
        for (int k = 0; k < ackdly; k++) begin
            bus_respcyc = 1'b1;
            bus_resp    = 64'hDEAD;
            #1;
            check_eq("rd_stray_respack", 64'(bus_respack), 64'd0);
            check_eq("rd_addr_hold", bus_req, a_exp);
            cyc();
        end
        bus_respcyc = 1'b0;
        bus_reqack  = 1'b1;
        #1;
        check_eq("rd_bus_reqcyc", 64'(bus_reqcyc), 64'd1);
        check_eq("rd_bus_addr", bus_req, a_exp);
        check_eq("rd_bus_tag", 64'(bus_reqtag), 64'(t_exp));
        cyc();
        bus_reqack = 1'b0;
        for (int b = 0; b < 8; b++) begin
            bus_respcyc = 1'b1;
            bus_resp    = dbase + 64'(b);
            #1;
            check_eq("rd_bus_respack", 64'(bus_respack), 64'd1);
            cyc();
        end
        bus_respcyc = 1'b0;
        respack     = onehot;
        for (int b = 0; b < 8; b++) begin
            if (b == sbeat) begin
                respack = 2'b00;
                for (int s = 0; s < slen; s++) begin
                    #1;
                    check_eq("rd_resp_stall_cyc", 64'(respcyc), 64'(onehot));
                    check_eq("rd_resp_stall_data", resp, dbase + 64'(b));
                    cyc();
                end
                respack = onehot;
            end
            #1;
            check_eq("rd_respcyc", 64'(respcyc), 64'(onehot));
            check_eq("rd_resp", resp, dbase + 64'(b));
            check_eq("rd_resptag", 64'(resptag), 64'(t_exp));
            cyc();
        end
        respack = 2'b00;
        #1;
        check_eq("rd_done_respcyc", 64'(respcyc), 64'd0);
        check_eq("rd_done_busreq", 64'(bus_reqcyc), 64'd0);
    endtask

    initial begin
        int g, w, acks, n;
        reset = 1'b0;
        reqcyc = '0; req = '0; reqtag = '0; respack = '0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
        b_reqcyc = '0; b_req = '0; b_reqtag = '0; b_respack = '0;
        b_bus_reqack = 1'b0; b_bus_respcyc = 1'b0; b_bus_resp = '0; b_bus_resptag = '0;
        cyc();
        cyc();
        check_eq("rst_a_ctrl", 64'({reqack, respcyc, bus_reqcyc, bus_respack, resptag}), 64'd0);
        check_eq("rst_a_resp", resp, 64'd0);
        check_eq("rst_a_bus", {bus_req[50:0], bus_reqtag}, 64'd0);
        check_eq("rst_b_ctrl", 64'({b_reqack, b_respcyc, b_bus_reqcyc, b_bus_respack, b_resptag}), 64'd0);
        check_eq("rst_b_data", {b_resp, b_bus_req}, 64'd0);
        reset = 1'b1;
        cyc();

        // Basic read on channel 0
        read_txn(2'b01, 0, 64'h1000, 64'h11, 0, -1, 0, 1'b0);

        // Write burst on channel 1 with a requester gap and a bus stall
        reqcyc = 2'b10;
        req[64 +: 64]   = 64'h2000;
        reqtag[13 +: 13] = 13'h1055;
        wait_grant(g, w);
        check_eq("wr_grant", 64'(g), 64'd1);
        acks = 1;
        req[64 +: 64] = 64'hA0;
        cyc();
        for (int b = 0; b < 8; b++) begin
            if (b == 3) begin
                reqcyc = 2'b00;
                #1;
                check_eq("wr_gap_ack", 64'(reqack), 64'd0);
                cyc();
                reqcyc = 2'b10;
            end
            req[64 +: 64] = 64'hA0 + 64'(b);
            #1;
            check_eq("wr_beat_ack", 64'(reqack), 64'd2);
            if (reqack[1]) acks++;
            cyc();
        end
        reqcyc = 2'b00;
        #1;
        check_eq("wr_ack_count", 64'(acks), 64'd9);
        check_eq("wr_addr_cyc", 64'(bus_reqcyc), 64'd1);
        check_eq("wr_addr", bus_req, 64'h2000);
        check_eq("wr_tag", 64'(bus_reqtag), 64'h1055);
        bus_reqack = 1'b1;
        cyc();
        bus_respcyc = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (b == 2) begin
                bus_reqack = 1'b0;
                #1;
                check_eq("wr_data_hold", bus_req, 64'hA2);
                cyc();
                bus_reqack = 1'b1;
            end
            #1;
            check_eq("wr_data", bus_req, 64'hA0 + 64'(b));
            check_eq("wr_stray_respack", 64'(bus_respack), 64'd0);
            check_eq("wr_no_resp", 64'(respcyc), 64'd0);
            cyc();
        end
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        #1;
        check_eq("wr_done_busreq", 64'(bus_reqcyc), 64'd0);
        check_eq("wr_done_respcyc", 64'(respcyc), 64'd0);

        // Both channels held requesting across four reads
        for (int i = 0; i < 4; i++) begin
`ifdef SYSBUS_ARB_RR_EN
            read_txn(2'b11, i % 2, 64'h3000, 64'h40 + 64'(i) * 64'h8, 0, -1, 0, 1'b1);
`else
            read_txn(2'b11, 0, 64'h3000, 64'h40 + 64'(i) * 64'h8, 0, -1, 0, 1'b1);
`endif
        end
        reqcyc = 2'b00;

        // Backpressure: bus ack delayed 3 cycles, response beat 4 stalled 2 cycles
        read_txn(2'b01, 0, 64'h4000, 64'h81, 3, 4, 2, 1'b0);

        // Reset asserted while presenting response beat 3
        reqcyc = 2'b01;
        req[0 +: 64]   = 64'h6000;
        reqtag[0 +: 13] = 13'h0AB;
        wait_grant(g, w);
        reqcyc = 2'b00;
        cyc();
        bus_reqack = 1'b1;
        cyc();
        bus_reqack = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus_respcyc = 1'b1;
            bus_resp    = 64'h60 + 64'(b);
            cyc();
        end
        bus_resp = 64'h63;
        reset = 1'b0;
        #1;
        check_eq("rst_mid_respack", 64'(bus_respack), 64'd1);
        cyc();
        reset = 1'b1;
        #1;
        check_eq("rst_mid_ctrl", 64'({reqack, respcyc, bus_reqcyc, bus_respack, resptag}), 64'd0);
        check_eq("rst_mid_resp", resp, 64'd0);
        check_eq("rst_mid_bus", {bus_req[50:0], bus_reqtag}, 64'd0);
        bus_respcyc = 1'b0;
        // Pointer restarts at channel 0 after reset
        read_txn(2'b11, 0, 64'h7000, 64'h31, 0, -1, 0, 1'b0);

        // Instance B: read on channel 3
        b_reqcyc = 4'b1000;
        b_req[96 +: 32]  = 32'h5000;
        b_reqtag[24 +: 8] = 8'h21;
        cyc();
        check_eq("b_grant", 64'(b_reqack), 64'h8);
        b_reqcyc = 4'b0000;
        cyc();
        check_eq("b_bus_addr", 64'(b_bus_req), 64'h5000);
        check_eq("b_bus_tag", 64'(b_bus_reqtag), 64'h21);
        b_bus_reqack = 1'b1;
        cyc();
        b_bus_reqack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            b_bus_respcyc = 1'b1;
            b_bus_resp    = 32'h70 + 32'(b);
            #1;
            check_eq("b_bus_respack", 64'(b_bus_respack), 64'd1);
            cyc();
        end
        b_bus_respcyc = 1'b0;
        b_respack = 4'b1111;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (b_respcyc != 4'b0000) begin
                check_eq("b_respcyc", 64'(b_respcyc), 64'h8);
                check_eq("b_resp", 64'(b_resp), 64'h70 + 64'(n));
                check_eq("b_resptag", 64'(b_resptag), 64'h21);
                n++;
            end
            cyc();
        end
        b_respack = 4'b0000;
        check_eq("b_beat_count", 64'(n), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
